// File: rtl/prover_compute_v_early_gates.sv
// rtl/prover_compute_v_early_gates.sv - four-lane early-layer V evaluator over F_Q
// Lanes run in lockstep: gate values, chi weighting, adder-tree sum, beta scale.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif
`ifndef GATEFN_BITS
`define GATEFN_BITS 2
`endif
`ifndef GATEFN_ADD
`define GATEFN_ADD 2'd0
`endif
`ifndef GATEFN_MUL
`define GATEFN_MUL 2'd1
`endif
`ifndef GATEFN_MUX
`define GATEFN_MUX 2'd2
`endif

package prover_compute_v_early_gates_pkg;
  localparam int W = `F_NBITS;
  localparam logic [W-1:0] Q = `F_Q;

  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, Q}) ? W'(s - {1'b0, Q}) : s[W-1:0];
  endfunction
endpackage

// Reduction relies on Q = 2^W - 1, so 2^W folds back as 1.
module prover_field_mul
  import prover_compute_v_early_gates_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] mul_out
);
  logic [2*W-1:0] prod;
  logic [W:0]     fold1;
  logic [W:0]     fold2;

  always_comb begin
    prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    fold1   = {1'b0, prod[W-1:0]} + {1'b0, prod[2*W-1:W]};
    fold2   = {1'b0, fold1[W-1:0]} + {{W{1'b0}}, fold1[W]};
    mul_out = (fold2 >= {1'b0, Q}) ? W'(fold2 - {1'b0, Q}) : fold2[W-1:0];
  end
endmodule

// Heap-ordered binary tree: leaves at n..2n-1, node i sums children 2i and 2i+1.
module prover_field_add_tree
  import prover_compute_v_early_gates_pkg::*;
#(
  parameter int n = 8
) (
  input  logic [n-1:0][W-1:0] in,
  output logic [W-1:0]        out
);
  always_comb begin : tree
    logic [W-1:0] node [1:2*n-1];
    for (int i = 0; i < n; i++) node[n+i] = in[i];
    for (int i = n - 1; i >= 1; i--) node[i] = add_mod(node[2*i], node[2*i+1]);
    out = node[1];
  end
endmodule

module prover_compute_v_early_gates
  import prover_compute_v_early_gates_pkg::*;
#(
  parameter int ngates   = 8,
  parameter int ninputs  = 8,
  parameter int nmuxsels = 1,
  localparam int ninbits = $clog2(ninputs),
  localparam int muxbits = (nmuxsels > 1) ? $clog2(nmuxsels) : 1,
  parameter logic [`GATEFN_BITS*ngates-1:0] gates_fn  = '0,
  parameter logic [ngates*ninbits-1:0]      gates_in0 = '0,
  parameter logic [ngates*ninbits-1:0]      gates_in1 = '0,
  parameter logic [ngates*muxbits-1:0]      gates_mux = '0
) (
  input  logic                                   clk,
  input  logic                                   rstb,
  input  logic                                   en,
  input  logic                                   mask_en,
  input  logic [ninputs-1:0][3:0][`F_NBITS-1:0] v_in,
  input  logic [ngates-1:0][`F_NBITS-1:0]        z1_chi,
  input  logic [3:0][`F_NBITS-1:0]               beta_in,
  input  logic [nmuxsels-1:0]                    mux_sel,
  output logic                                   in_ready,
  output logic                                   out_ready,
  output logic                                   out_ready_pulse,
  output logic [3:0][`F_NBITS-1:0]               v_out
);
  localparam int gbits = (ngates > 1) ? $clog2(ngates) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GATE, S_CHI, S_SUM, S_BETA, S_DONE} state_t;

  state_t                         state;
  logic [gbits-1:0]               g_idx;
  logic                           last_gate;
  logic [3:0][ngates-1:0][W-1:0]  gate_val;
  logic [3:0][ngates-1:0][W-1:0]  term;
  logic [3:0][W-1:0]              sum_reg;
  logic [3:0][W-1:0]              op_a, op_b;
  logic [3:0][W-1:0]              mul_a, mul_b, mul_out;
  logic [3:0][W-1:0]              gate_res, tree_out;
  logic [`GATEFN_BITS-1:0]        fn;
  logic [ninbits-1:0]             in0, in1;
  logic [muxbits-1:0]             msel_idx;
  logic [2**muxbits-1:0]          sel_ext;
  logic                           sel;

  always_comb begin : gate_decode
    fn       = gates_fn[int'(g_idx)*`GATEFN_BITS +: `GATEFN_BITS];
    in0      = gates_in0[int'(g_idx)*ninbits +: ninbits];
    in1      = gates_in1[int'(g_idx)*ninbits +: ninbits];
    msel_idx = gates_mux[int'(g_idx)*muxbits +: muxbits];
    sel_ext  = '0;
    for (int i = 0; i < nmuxsels; i++) sel_ext[i] = mux_sel[i];
    sel       = sel_ext[msel_idx];
    last_gate = (g_idx == gbits'(ngates - 1));
  end

  // One multiplier per lane is time-shared across the GATE, CHI and BETA phases.
  always_comb begin : mul_operands
    for (int j = 0; j < 4; j++) begin
      op_a[j]  = v_in[in0][j];
      op_b[j]  = v_in[in1][j];
      mul_a[j] = '0;
      mul_b[j] = '0;
      case (state)
        S_GATE: begin
          mul_a[j] = op_a[j];
          mul_b[j] = op_b[j];
        end
        S_CHI: begin
          mul_a[j] = gate_val[j][g_idx];
          mul_b[j] = z1_chi[g_idx];
        end
        S_BETA: begin
          mul_a[j] = sum_reg[j];
          mul_b[j] = beta_in[j];
        end
        default: ;
      endcase
    end
  end

  always_comb begin : gate_eval
    for (int j = 0; j < 4; j++) begin
      case (fn)
        `GATEFN_ADD: gate_res[j] = add_mod(op_a[j], op_b[j]);
        `GATEFN_MUL: gate_res[j] = mul_out[j];
        `GATEFN_MUX: gate_res[j] = sel ? op_b[j] : op_a[j];
        default:     gate_res[j] = '0;
      endcase
    end
  end

  for (genvar j = 0; j < 4; j++) begin : g_lane
    prover_field_mul MulInst (
      .a       (mul_a[j]),
      .b       (mul_b[j]),
      .mul_out (mul_out[j])
    );

    prover_field_add_tree #(.n(ngates)) iAddT (
      .in  (term[j]),
      .out (tree_out[j])
    );
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state           <= S_IDLE;
      g_idx           <= '0;
      in_ready        <= 1'b1;
      out_ready       <= 1'b1;
      out_ready_pulse <= 1'b0;
      v_out           <= '0;
      gate_val        <= '0;
      term            <= '0;
      sum_reg         <= '0;
    end else begin
      out_ready_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && !mask_en && in_ready) begin
            state     <= S_GATE;
            g_idx     <= '0;
            in_ready  <= 1'b0;
            out_ready <= 1'b0;
          end
        end
        S_GATE: begin
          for (int j = 0; j < 4; j++) gate_val[j][g_idx] <= gate_res[j];
          if (last_gate) begin
            g_idx <= '0;
            state <= S_CHI;
          end else begin
            g_idx <= g_idx + 1'b1;
          end
        end
        S_CHI: begin
          for (int j = 0; j < 4; j++) term[j][g_idx] <= mul_out[j];
          if (last_gate) begin
            g_idx <= '0;
            state <= S_SUM;
          end else begin
            g_idx <= g_idx + 1'b1;
          end
        end
        S_SUM: begin
          sum_reg <= tree_out;
          state   <= S_BETA;
        end
        S_BETA: begin
          v_out           <= mul_out;
          in_ready        <= 1'b1;
          out_ready       <= 1'b1;
          out_ready_pulse <= 1'b1;
          state           <= S_DONE;
        end
        // A start request seen here is dropped; IDLE accepts the next one.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prover_compute_v_early_gates.sv
// tb/tb_prover_compute_v_early_gates.sv - randomized scoreboard bench for prover_compute_v_early_gates
module tb_prover_compute_v_early_gates;
  localparam int W = 61;
  localparam logic [W-1:0] Q = 61'h1FFF_FFFF_FFFF_FFFF;
  localparam int LAT_MAX = 3 * 8 + 32;
  localparam logic [15:0] FN_ADDMUL = 16'h4444;
  localparam logic [15:0] FN_MUX    = 16'hAAAA;
  localparam logic [23:0] IN0 = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] IN1 = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  typedef logic [3:0][W-1:0] lanes_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic en = 1'b0;
  logic mask_en = 1'b0;
  logic [7:0][3:0][W-1:0] v_in;
  logic [7:0][W-1:0] z1_chi;
  lanes_t beta_in;
  logic [0:0] mux_sel;

  logic in_ready_a, out_ready_a, pulse_a;
  logic in_ready_m, out_ready_m, pulse_m;
  lanes_t v_out_a, v_out_m;

  int checks = 0;
  int errors = 0;
  int runs = 0;
  int pulses_a = 0;
  int pulses_m = 0;
  int first_lat = 0;
  logic prev_pa = 1'b0;
  logic prev_pm = 1'b0;
  lanes_t exp_a[$];
  lanes_t exp_m[$];
  lanes_t last_a, last_m;

  prover_compute_v_early_gates #(
    .ngates(8), .ninputs(8), .nmuxsels(1),
    .gates_fn(FN_ADDMUL), .gates_in0(IN0), .gates_in1(IN1), .gates_mux(8'h00)
  ) dut_a (
    .clk(clk), .rstb(rstb), .en(en), .mask_en(mask_en),
    .v_in(v_in), .z1_chi(z1_chi), .beta_in(beta_in), .mux_sel(mux_sel),
    .in_ready(in_ready_a), .out_ready(out_ready_a),
    .out_ready_pulse(pulse_a), .v_out(v_out_a)
  );

  prover_compute_v_early_gates #(
    .ngates(8), .ninputs(8), .nmuxsels(1),
    .gates_fn(FN_MUX), .gates_in0(IN0), .gates_in1(IN1), .gates_mux(8'h00)
  ) dut_m (
    .clk(clk), .rstb(rstb), .en(en), .mask_en(mask_en),
    .v_in(v_in), .z1_chi(z1_chi), .beta_in(beta_in), .mux_sel(mux_sel),
    .in_ready(in_ready_m), .out_ready(out_ready_m),
    .out_ready_pulse(pulse_m), .v_out(v_out_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [W-1:0] addm(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] s;
    s = 64'(a) + 64'(b);
    return W'(s % 64'(Q));
  endfunction

  function automatic logic [W-1:0] mulm(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [127:0] p;
    p = 128'(a) * 128'(b);
    return W'(p % 128'(Q));
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    return W'(x % 64'(Q));
  endfunction

  // Reference: beta * sum_g chi_g * f_g(v[g], v[7-g]), gates even=ADD odd=MUL, or all MUX.
  function automatic lanes_t model(input bit mux);
    lanes_t r;
    logic [W-1:0] s, a, b, f;
    for (int j = 0; j < 4; j++) begin
      s = '0;
      for (int g = 0; g < 8; g++) begin
        a = v_in[g][j];
        b = v_in[7-g][j];
        if (mux) f = mux_sel[0] ? b : a;
        else if (g % 2 == 0) f = addm(a, b);
        else f = mulm(a, b);
        s = addm(s, mulm(z1_chi[g], f));
      end
      r[j] = mulm(beta_in[j], s);
    end
    return r;
  endfunction

  task automatic randomize_inputs();
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 4; j++) v_in[w][j] = rnd();
    for (int g = 0; g < 8; g++) z1_chi[g] = rnd();
    for (int j = 0; j < 4; j++) beta_in[j] = rnd();
  endtask

  always @(negedge clk) begin
    if (pulse_a) begin
      lanes_t e;
      pulses_a++;
      chk("pulse_width_a", 64'(prev_pa), 64'd0);
      chk("ready_at_pulse_a", 64'({in_ready_a, out_ready_a}), 64'd3);
      if (exp_a.size() == 0) chk("unexpected_pulse_a", 64'(exp_a.size()), 64'd1);
      else begin
        e = exp_a.pop_front();
        for (int j = 0; j < 4; j++) chk($sformatf("v_out_a[%0d]", j), 64'(v_out_a[j]), 64'(e[j]));
      end
    end
    if (pulse_m) begin
      lanes_t e;
      pulses_m++;
      chk("pulse_width_m", 64'(prev_pm), 64'd0);
      chk("ready_at_pulse_m", 64'({in_ready_m, out_ready_m}), 64'd3);
      if (exp_m.size() == 0) chk("unexpected_pulse_m", 64'(exp_m.size()), 64'd1);
      else begin
        e = exp_m.pop_front();
        for (int j = 0; j < 4; j++) chk($sformatf("v_out_m[%0d]", j), 64'(v_out_m[j]), 64'(e[j]));
      end
    end
    prev_pa = pulse_a;
    prev_pm = pulse_m;
  end

  // Called during an idle cycle; returns during the first idle cycle after DONE.
  task automatic run(input bit busy_en, input bit done_en);
    int cyc;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("hold_a[%0d]", j), 64'(v_out_a[j]), 64'(last_a[j]));
      chk($sformatf("hold_m[%0d]", j), 64'(v_out_m[j]), 64'(last_m[j]));
    end
    last_a = model(1'b0);
    last_m = model(1'b1);
    exp_a.push_back(last_a);
    exp_m.push_back(last_m);
    runs++;
    en = 1'b1;
    mask_en = 1'b0;
    @(posedge clk) #1;
    en = 1'b0;
    mask_en = 1'b1;
    cyc = 1;
    chk("busy_flags", 64'({in_ready_a, in_ready_m, out_ready_a, out_ready_m}), 64'd0);
    if (busy_en) begin
      mask_en = 1'b0;
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk) #1;
        cyc++;
      end
      en = 1'b0;
    end
    while (!(in_ready_a && in_ready_m) && cyc < LAT_MAX + 4) begin
      @(posedge clk) #1;
      cyc++;
    end
    mask_en = 1'b0;
    chk("latency_bound", 64'(cyc <= LAT_MAX), 64'd1);
    if (first_lat == 0) first_lat = cyc;
    else chk("latency_const", 64'(cyc), 64'(first_lat));
    if (done_en) begin
      en = 1'b1;
      @(posedge clk) #1;
      en = 1'b0;
      chk("done_cycle_en_ignored", 64'(in_ready_a && in_ready_m), 64'd1);
    end else begin
      @(posedge clk) #1;
    end
  endtask

  initial begin
    v_in = '0;
    z1_chi = '0;
    beta_in = '0;
    mux_sel = 1'b0;
    last_a = '0;
    last_m = '0;

    #1 rstb = 1'b1;
    #2;
    chk("reset_in_ready", 64'({in_ready_a, in_ready_m}), 64'd3);
    chk("reset_out_ready", 64'({out_ready_a, out_ready_m}), 64'd3);
    chk("reset_pulse", 64'({pulse_a, pulse_m}), 64'd0);
    chk("reset_v_out_a", 64'(v_out_a[0] | v_out_a[1] | v_out_a[2] | v_out_a[3]), 64'd0);
    @(posedge clk) #1;
    rstb = 1'b0;
    @(posedge clk) #1;

    for (int r = 0; r < 6; r++) begin
      randomize_inputs();
      mux_sel = 1'(r % 2);
      run(r == 2, r == 4);
    end

    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 4; j++) v_in[w][j] = Q - 1;
    for (int g = 0; g < 8; g++) z1_chi[g] = 61'd1;
    for (int j = 0; j < 4; j++) beta_in[j] = 61'd1;
    mux_sel = 1'b0;
    run(1'b0, 1'b0);

    randomize_inputs();
    z1_chi = '0;
    run(1'b0, 1'b0);

    randomize_inputs();
    beta_in = '0;
    run(1'b0, 1'b0);

    randomize_inputs();
    mux_sel = 1'b0;
    run(1'b1, 1'b0);
    randomize_inputs();
    mux_sel = 1'b1;
    run(1'b1, 1'b0);

    mask_en = 1'b1;
    en = 1'b1;
    repeat (3) @(posedge clk) #1;
    chk("mask_en_blocks_start", 64'({in_ready_a, out_ready_a, in_ready_m, out_ready_m}), 64'hF);
    en = 1'b0;
    mask_en = 1'b0;

    randomize_inputs();
    en = 1'b1;
    @(posedge clk) #1;
    en = 1'b0;
    repeat (4) @(posedge clk) #1;
    #2 rstb = 1'b1;
    #1;
    chk("async_reset_ready", 64'({in_ready_a, out_ready_a, in_ready_m, out_ready_m}), 64'hF);
    chk("async_reset_v_out_a", 64'(v_out_a[0] | v_out_a[1] | v_out_a[2] | v_out_a[3]), 64'd0);
    chk("async_reset_v_out_m", 64'(v_out_m[0] | v_out_m[1] | v_out_m[2] | v_out_m[3]), 64'd0);
    last_a = '0;
    last_m = '0;
    @(posedge clk) #1;
    rstb = 1'b0;
    repeat (30) @(posedge clk) #1;

    randomize_inputs();
    mux_sel = 1'b1;
    run(1'b0, 1'b0);

    repeat (3) @(posedge clk) #1;
    chk("queue_a_drained", 64'(exp_a.size()), 64'd0);
    chk("queue_m_drained", 64'(exp_m.size()), 64'd0);
    chk("pulses_a_per_run", 64'(pulses_a), 64'(runs));
    chk("pulses_m_per_run", 64'(pulses_m), 64'(runs));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
